// File: rtl/mul_bcd_seq.sv
// mul_bcd_seq: sequential 4x4 multiply followed by binary-to-BCD conversion.
// A start request latches the operands. A 4-step shift-add loop forms the
// 8-bit product, and an 8-step double-dabble loop converts it to BCD.
// The product and the digits are registered for the seven-segment scanner.
// Optional macro LEADING_ZERO_BLANK_EN drives the per-digit blank mask so
// that leading zeros are suppressed. Without it, blank is tied to 4'b0000.
module mul_bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic [3:0] thousands,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [3:0] blank
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_BCD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic [7:0]  acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [19:0] scratch_q, scratch_d;
  logic [7:0]  product_q, product_d;
  logic [3:0]  thousands_q, thousands_d;
  logic [3:0]  hundreds_q, hundreds_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;

  // One double-dabble step on {12-bit BCD, 8-bit binary}. Each BCD nibble
  // that is 5 or more gets 3 added to it, then the whole register shifts
  // left by one bit.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int k = 0; k < 3; k++) begin
      if (t[8+4*k +: 4] >= 4'd5) begin
        t[8+4*k +: 4] = t[8+4*k +: 4] + 4'd3;
      end
    end
    return {t[18:0], 1'b0};
  endfunction

  // State and datapath registers. Reset aborts any operation in progress
  // and clears all of the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      scratch_q   <= '0;
      product_q   <= '0;
      thousands_q <= '0;
      hundreds_q  <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      scratch_q   <= scratch_d;
      product_q   <= product_d;
      thousands_q <= thousands_d;
      hundreds_q  <= hundreds_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
    end
  end

  // Next-state logic and datapath step logic. The output registers change
  // only on the transition into DONE.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    scratch_d   = scratch_q;
    product_d   = product_q;
    thousands_d = thousands_q;
    hundreds_d  = hundreds_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (b_q[cnt_q[1:0]]) begin
          acc_d = acc_q + ({4'b0000, a_q} << cnt_q[1:0]);
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          cnt_d     = '0;
          scratch_d = {12'b0, acc_d};
          state_d   = S_BCD;
        end
      end
      S_BCD: begin
        scratch_d = dabble_step(scratch_q);
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          cnt_d       = '0;
          product_d   = acc_q;
          thousands_d = 4'd0;
          hundreds_d  = scratch_d[19:16];
          tens_d      = scratch_d[15:12];
          ones_d      = scratch_d[11:8];
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign product   = product_q;
  assign thousands = thousands_q;
  assign hundreds  = hundreds_q;
  assign tens      = tens_q;
  assign ones      = ones_q;

`ifdef LEADING_ZERO_BLANK_EN
  // Blank each leading zero digit. The ones digit is always shown.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (thousands_q == 4'd0);
    blank[2] = blank[3] & (hundreds_q == 4'd0);
    blank[1] = blank[2] & (tens_q == 4'd0);
    blank[0] = 1'b0;
  end
`else
  assign blank = 4'b0000;
`endif

endmodule

// File: tb/tb_mul_bcd_seq.sv
// Testbench for mul_bcd_seq. Each result is compared with an arithmetic
// model: product = a*b, and the decimal digits come from division and
// modulo by 10.
module tb_mul_bcd_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic [3:0] thousands;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [3:0] blank;

  int checks = 0;
  int errors = 0;

  mul_bcd_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a_in),
    .b         (b_in),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .blank     (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs {product, thousands, hundreds, tens, ones, blank}.
  function automatic logic [31:0] model(input int x, input int y);
    int p, h, t, o;
    logic [3:0] bl;
    p = x * y;
    h = p / 100;
    t = (p / 10) % 10;
    o = p % 10;
    bl = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    bl[3] = 1'b1;
    bl[2] = (h == 0);
    bl[1] = bl[2] && (t == 0);
`endif
    return {p[7:0], 4'd0, h[3:0], t[3:0], o[3:0], bl};
  endfunction

  function automatic logic [31:0] observed();
    return {product, thousands, hundreds, tens, ones, blank};
  endfunction

  // Drive start with the given operands. The task returns #1 after the
  // accepting edge (E0), with start already dropped.
  task automatic start_op(input int x, input int y);
    @(negedge clk);
    a_in  = 4'(x);
    b_in  = 4'(y);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges until done is seen. lat is -1 if done never appears.
  task automatic wait_done(output int lat);
    bit found;
    found = 0;
    lat = -1;
    for (int n = 1; n <= 20 && !found; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        found = 1;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp_v;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_v = model(0, 0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (observed() !== exp_v) begin errors++; $display("[TB] FAIL reset_outputs: got %h expected %h", observed(), exp_v); end
  endtask

  task automatic test_max();
    int lat;
    logic [31:0] exp_v;
    start_op(15, 15);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL max_busy_after_accept: got %b expected 1", busy); end
    wait_done(lat);
    exp_v = model(15, 15);
    checks++;
    if (lat !== 12) begin errors++; $display("[TB] FAIL max_latency: got %0d expected 12", lat); end
    checks++;
    if (observed() !== exp_v) begin errors++; $display("[TB] FAIL max_result: got %h expected %h", observed(), exp_v); end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL max_after_done: busy/done got %b expected 00", {busy, done}); end
    checks++;
    if (observed() !== exp_v) begin errors++; $display("[TB] FAIL max_hold: got %h expected %h", observed(), exp_v); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] exp_v;
    start_op(3, 3);
    wait_done(lat);
    exp_v = model(3, 3);
    checks++;
    if (observed() !== exp_v) begin errors++; $display("[TB] FAIL b2b_first: got %h expected %h", observed(), exp_v); end
    // Start is already high during the DONE cycle. It must be ignored
    // there and accepted only at the next edge.
    a_in = 4'd0; b_in = 4'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL b2b_idle_gap: busy/done got %b expected 00", {busy, done}); end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    exp_v = model(0, 7);
    checks++;
    if (lat !== 12) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 12", lat); end
    checks++;
    if (observed() !== exp_v) begin errors++; $display("[TB] FAIL b2b_second: got %h expected %h", observed(), exp_v); end
  endtask

  task automatic test_start_while_busy();
    int pulses, lat;
    logic [31:0] res, exp_v;
    pulses = 0; lat = -1; res = '0;
    start_op(10, 12);
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      if (n == 4) begin #1 a_in = 4'd1; b_in = 4'd1; start = 1'b1; end
      if (n == 5) begin #1 start = 1'b0; end
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        if (pulses == 1) begin lat = n; res = observed(); end
      end
    end
    exp_v = model(10, 12);
    checks++;
    if (pulses !== 1) begin errors++; $display("[TB] FAIL busy_start_pulses: got %0d expected 1", pulses); end
    checks++;
    if (lat !== 12) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d expected 12", lat); end
    checks++;
    if (res !== exp_v) begin errors++; $display("[TB] FAIL busy_start_result: got %h expected %h", res, exp_v); end
  endtask

  task automatic test_reset_mid();
    int pulses, lat;
    logic [31:0] exp_v;
    pulses = 0;
    start_op(9, 9);
    for (int n = 1; n <= 6; n++) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    exp_v = model(0, 0);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_busy_done: got %b expected 00", {busy, done}); end
    checks++;
    if (observed() !== exp_v) begin errors++; $display("[TB] FAIL rstmid_outputs: got %h expected %h", observed(), exp_v); end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("[TB] FAIL rstmid_no_done: got %0d pulses expected 0", pulses); end
    start_op(9, 9);
    wait_done(lat);
    exp_v = model(9, 9);
    checks++;
    if (lat !== 12) begin errors++; $display("[TB] FAIL rstmid_rerun_latency: got %0d expected 12", lat); end
    checks++;
    if (observed() !== exp_v) begin errors++; $display("[TB] FAIL rstmid_rerun_result: got %h expected %h", observed(), exp_v); end
  endtask

  task automatic test_operand_change();
    int lat;
    logic [31:0] exp_v;
    start_op(6, 7);
    a_in = 4'd15; b_in = 4'd15;
    wait_done(lat);
    exp_v = model(6, 7);
    checks++;
    if (observed() !== exp_v) begin errors++; $display("[TB] FAIL operand_change: got %h expected %h", observed(), exp_v); end
  endtask

  task automatic test_random();
    int lat, x, y;
    logic [31:0] exp_v;
    for (int i = 0; i < 25; i++) begin
      x = int'($urandom_range(15));
      y = int'($urandom_range(15));
      start_op(x, y);
      a_in = 4'($urandom_range(15));
      b_in = 4'($urandom_range(15));
      wait_done(lat);
      exp_v = model(x, y);
      checks++;
      if (lat !== 12 || observed() !== exp_v)
        begin errors++; $display("[TB] FAIL random_%0dx%0d: got lat=%0d res=%h expected lat=12 res=%h", x, y, lat, observed(), exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid();
    test_operand_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_bcd_seq.md
# mul_bcd_seq

Sequential multiply-and-convert controller for the 4x4 product display path. On a start request it latches two 4-bit operands, forms the 8-bit product with a 4-step shift-add loop, converts it to BCD with an 8-step double-dabble loop, and presents registered digits to the seven-segment scanner. It replaces the purely combinational multiply/convert chain with a start/busy/done-sequenced datapath.

## Interface

Parameters:
- none; operand width is fixed at 4 bits, product at 8 bits, four BCD digits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- a  input  4  multiplicand, unsigned; latched when start is accepted.
- b  input  4  multiplier, unsigned; latched when start is accepted.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; results valid and updated.
- product  output  8  registered binary product.
- thousands  output  4  BCD digit 3 (always 0 for this operand range).
- hundreds  output  4  BCD digit 2.
- tens  output  4  BCD digit 1.
- ones  output  4  BCD digit 0.
- blank  output  4  per-digit blank mask for the scanner, bit 3 = thousands.

## Operation

- FSM states: IDLE, MUL, BCD, DONE.
- IDLE: when start=1, latch a and b, clear accumulator, clear step counter, go to MUL.
- MUL: 4 steps. Each step adds the shifted multiplicand to the accumulator if the current multiplier bit is 1, then advances. After step 3, go to BCD with the step counter cleared.
- BCD: 8 steps of double-dabble on a 20-bit scratch register: {12-bit BCD, 8-bit product}. In each step, add 3 to every BCD nibble that is ≥5, then shift the whole register left by 1. After step 7, go to DONE.
- DONE: on entry, load product and the four digit output registers, and assert done. Unconditionally return to IDLE on the next edge.
- Output registers hold their values until the next DONE entry or reset.
- start while busy, including the DONE cycle, is ignored. It is not queued.
- a and b changing after acceptance have no effect.
- Arithmetic is unsigned throughout. The accumulator is 8 bits and cannot overflow, since 15×15=225.

## Timing

- Start accepted at edge E0, so busy=1 from E0.
- MUL steps execute on edges E1–E4. BCD steps execute on edges E5–E12.
- DONE is entered at E12. done=1 and the new outputs are visible in the cycle after E12. Latency is 12 cycles from acceptance to done.
- At E13 the FSM returns to IDLE and busy=0. The earliest next start accepted is at E14.
- Reset values: state IDLE; busy=0, done=0, product=0, all digits=0; blank=4'b0000 without the macro and 4'b1110 with it.
- Reset asserted mid-operation: the FSM aborts immediately to IDLE, outputs clear to their reset values, and no done pulse is produced.

## Configuration

- LEADING_ZERO_BLANK_EN defined: blank is driven combinationally from the output digit registers.
  - blank[3] = (thousands==0)
  - blank[2] = blank[3] & (hundreds==0)
  - blank[1] = blank[2] & (tens==0)
  - blank[0] = 0, so the ones digit is always shown.
- LEADING_ZERO_BLANK_EN undefined: blank is tied to 4'b0000 and all digits are displayed.

## Test plan

- Reset: assert rst for 3 cycles → busy=0, done=0, product=0, all digits 0, blank per macro.
- 15×15: start one cycle → done exactly 12 cycles after acceptance, product=8'd225, digits 0/2/2/5, with blank=4'b1000 when the macro is defined.
- 3×3, then 0×7: run back-to-back → first result product=9, digits 0/0/0/9, blank=4'b1110 (macro defined) or 4'b0000 (undefined); second result product=0, ones=0, blank=4'b1110 (macro defined).
- Start while busy: start 10×12, then pulse start with 1×1 at E5 → only one done pulse, with product=120 and digits 0/1/2/0; the 1×1 request is dropped.
- Reset mid-operation: start 9×9, assert rst at E7 → outputs return to 0 and no done pulse; a subsequent 9×9 yields 81 after 12 cycles.
- Operand change: start 6×7, change a and b to 15 at E1 → result is 42, digits 0/0/4/2.
